// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory arbiter that merges the Ibex instr/data
// ports and the Vicuna vector port into the single mmu request stream.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned PORT_INSTR = 0;
  localparam int unsigned PORT_DATA  = 1;
  localparam int unsigned PORT_VEC   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker: first requester at or above ptr_i, wrapping.
// The pointer register itself is owned by the instantiating block.
module rr_arbiter #(
  parameter int N_PORTS = 3,
  parameter int IDX_W   = 2
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [N_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic             found_s;
  logic             hit_s;
  logic [IDX_W-1:0] cand_s;

  // Scan candidates in priority order starting at the pointer; first hit wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      cand_s         = IDX_W'((int'(ptr_i) + i) % N_PORTS);
      hit_s          = ~found_s & req_i[cand_s];
      gnt_o[cand_s]  = gnt_o[cand_s] | hit_s;
      idx_o          = hit_s ? cand_s : idx_o;
      found_s        = found_s | hit_s;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges N requesters onto the single mmu port, one transaction in flight, with a
// timeout that closes transactions mmu never answers (posted writes succeed, reads error).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_W          = 32,
  parameter int N_PORTS        = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              req_i,
  input  logic [N_PORTS-1:0][31:0]        addr_i,
  input  logic [N_PORTS-1:0]              we_i,
  input  logic [N_PORTS-1:0][MEM_W/8-1:0] be_i,
  input  logic [N_PORTS-1:0][MEM_W-1:0]   wdata_i,
  output logic [N_PORTS-1:0]              gnt_o,
  output logic [N_PORTS-1:0]              rvalid_o,
  output logic [N_PORTS-1:0]              err_o,
  output logic [MEM_W-1:0]                rdata_o,
  output logic                            mem_req_o,
  output logic [31:0]                     mem_addr_o,
  output logic                            mem_we_o,
  output logic [MEM_W/8-1:0]              mem_be_o,
  output logic [MEM_W-1:0]                mem_wdata_o,
  input  logic                            mem_rvalid_i,
  input  logic                            mem_err_i,
  input  logic [MEM_W-1:0]                mem_rdata_i
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PORTS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_req_t         req_q, req_d;

  logic [N_PORTS-1:0] win_gnt_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               any_req_s;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt_s),
    .idx_o (win_idx_s)
  );

  assign any_req_s = |req_i;

  // Next-state, capture and response logic for the IDLE/BUSY controller.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    case (state_q)
      IDLE: begin
        // Grant is combinational, so it is masked while reset holds the block.
        if (!rst && any_req_s) begin
          gnt_o         = win_gnt_s;
          owner_d       = win_idx_s;
          req_d.addr    = addr_i[win_idx_s];
          req_d.we      = we_i[win_idx_s];
          req_d.be      = be_i[win_idx_s];
          req_d.wdata   = wdata_i[win_idx_s];
          cnt_d         = '0;
          rr_ptr_d      = (win_idx_s == IDX_LAST) ? '0 : win_idx_s + IDX_W'(1);
          state_d       = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid_i || mem_err_i) begin
          rvalid_o[owner_q] = 1'b1;
          err_o[owner_q]    = mem_err_i;
          rdata_o           = mem_rdata_i;
          state_d           = IDLE;
        end else if (cnt_q == TO_LAST) begin
          rvalid_o[owner_q] = 1'b1;
          err_o[owner_q]    = ~req_q.we;
          state_d           = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, owner, counter and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
    end
  end

  assign mem_req_o   = (state_q == BUSY);
  assign mem_addr_o  = req_q.addr;
  assign mem_we_o    = req_q.we;
  assign mem_be_o    = req_q.be;
  assign mem_wdata_o = req_q.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expected responses are queued when the mmu model
// answers (or a timeout is due) and checked by a monitor when rvalid_o fires.
module tb_mem_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [N-1:0]        req, we;
  logic [N-1:0][31:0]  addr;
  logic [N-1:0][3:0]   be;
  logic [N-1:0][W-1:0] wdata;
  logic [N-1:0]        gnt, rvalid, err;
  logic [W-1:0]        rdata;
  logic                mem_req, mem_we;
  logic [31:0]         mem_addr;
  logic [3:0]          mem_be;
  logic [W-1:0]        mem_wdata;
  logic                mem_rvalid, mem_err;
  logic [W-1:0]        mem_rdata;

  mem_arbiter #(.MEM_W(W), .N_PORTS(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .err_o(err), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_err_i(mem_err),
    .mem_rdata_i(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input int p, input logic e, input logic [31:0] d);
    exp_t x;
    x.port = p;
    x.err = e;
    x.rdata = d;
    sb.push_back(x);
  endtask

  // Response monitor: every rvalid pulse must match the head of the scoreboard.
  exp_t       mon_e;
  logic [2:0] mon_bit;
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid !== 3'b000) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rvalid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          mon_bit = 3'b001 << mon_e.port;
          check("rsp_port", 64'(rvalid), 64'(mon_bit));
          check("rsp_err", 64'(err), mon_e.err ? 64'(mon_bit) : 64'd0);
          check("rsp_rdata", 64'(rdata), 64'(mon_e.rdata));
        end
      end else begin
        check("rdata_idle", 64'(rdata), 64'd0);
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_rvalid"}, 64'(rvalid), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_rdata"}, 64'(rdata), 64'd0);
    check({tag, "_mreq"}, 64'(mem_req), 64'd0);
    check({tag, "_maddr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mwe"}, 64'(mem_we), 64'd0);
    check({tag, "_mbe"}, 64'(mem_be), 64'd0);
    check({tag, "_mwdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Transaction that mmu never answers; completes at BUSY cycle TO.
  task automatic run_timeout(input string tag, input int p, input logic w, input logic [31:0] a);
    step();
    req[p] = 1'b1; we[p] = w; addr[p] = a; be[p] = 4'h3; wdata[p] = 32'hCAFE_0000 + 32'(p);
    sample();
    check({tag, "_gnt"}, 64'(gnt), 64'(3'b001 << p));
    step();
    req[p] = 1'b0;
    mem_rdata = 32'h1234_5678;
    sample();
    check({tag, "_maddr"}, 64'(mem_addr), 64'(a));
    check({tag, "_mwe"}, 64'(mem_we), 64'(w));
    check({tag, "_mbe"}, 64'(mem_be), 64'h3);
    check({tag, "_mwdata"}, 64'(mem_wdata), 64'(32'hCAFE_0000 + 32'(p)));
    for (int c = 2; c < TO; c++) begin
      step();
      sample();
      check({tag, "_wait_rvalid"}, 64'(rvalid), 64'd0);
      check({tag, "_wait_mreq"}, 64'(mem_req), 64'd1);
    end
    step();
    push(p, ~w, 32'h0);
    sample();
    check({tag, "_last_maddr"}, 64'(mem_addr), 64'(a));
    step();
    mem_rdata = '0;
    sample();
    check({tag, "_after_mreq"}, 64'(mem_req), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    sample();
    check_outputs_zero("reset");
    step();
    rst = 1'b0;

    // Single read on port 1, answered at BUSY cycle 3.
    step();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0000_2000; be[1] = 4'hF;
    sample();
    check("rd_gnt", 64'(gnt), 64'b010);
    step();
    req[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        push(1, 1'b0, 32'hDEAD_BEEF);
      end
      sample();
      check("rd_mreq", 64'(mem_req), 64'd1);
      check("rd_maddr", 64'(mem_addr), 64'h2000);
      check("rd_no_gnt", 64'(gnt), 64'd0);
      if (c < 3) step();
    end
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    check("rd_after_mreq", 64'(mem_req), 64'd0);

    // Reset pulse so the pointer restarts at port 0, then round robin.
    step(); rst = 1'b1;
    sample();
    check_outputs_zero("rst2");
    step(); rst = 1'b0;
    for (int i = 0; i < N; i++) addr[i] = 32'h0000_1000 + 32'(16 * i);
    we = '0;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      mem_rvalid = 1'b0;
      sample();
      check("rr_gnt", 64'(gnt), 64'(3'b001 << (k % 3)));
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(k);
      push(k % 3, 1'b0, 32'hA000_0000 + 32'(k));
      sample();
      check("rr_busy_gnt", 64'(gnt), 64'd0);
      check("rr_maddr", 64'(mem_addr), 64'(32'h0000_1000 + 32'(16 * (k % 3))));
    end
    step();
    mem_rvalid = 1'b0; mem_rdata = '0; req = '0;
    sample();
    check("rr_end_mreq", 64'(mem_req), 64'd0);

    // Posted write and read that mmu never answers.
    run_timeout("to_wr", 2, 1'b1, 32'h0000_010B);
    run_timeout("to_rd", 0, 1'b0, 32'h0000_0115);

    // Error response without rvalid on a port 1 write.
    step();
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h0000_3000; wdata[1] = 32'h0000_00AA;
    sample();
    check("err_gnt", 64'(gnt), 64'b010);
    step();
    req[1] = 1'b0;
    sample();
    check("err_mreq", 64'(mem_req), 64'd1);
    step();
    mem_err = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    push(1, 1'b1, 32'h0BAD_0BAD);
    sample();
    step();
    mem_err = 1'b0; mem_rdata = '0;
    sample();
    check("err_after_mreq", 64'(mem_req), 64'd0);

    // Response arriving in the timeout cycle wins over the timeout.
    step();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0000_4000;
    sample();
    check("race_gnt", 64'(gnt), 64'b001);
    step();
    req[0] = 1'b0;
    for (int c = 2; c <= TO; c++) step();
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
    push(0, 1'b0, 32'h55AA_55AA);
    sample();
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    check("race_after_mreq", 64'(mem_req), 64'd0);

    // Reset during BUSY cycle 2 of a port 1 read drops it silently.
    step();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0000_5000;
    sample();
    check("mrst_gnt", 64'(gnt), 64'b010);
    step();
    req[1] = 1'b0;
    step();
    rst = 1'b1; req = 3'b110;
    sample();
    check_outputs_zero("mrst");
    step();
    rst = 1'b0;
    sample();
    check("mrst_regnt_p1", 64'(gnt), 64'b010);
    step();
    req[1] = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0051;
    push(1, 1'b0, 32'h0000_0051);
    sample();
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    check("mrst_regnt_p2", 64'(gnt), 64'b100);
    step();
    req[2] = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0052;
    push(2, 1'b0, 32'h0000_0052);
    sample();
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    sample();
    check("mrst_end_mreq", 64'(mem_req), 64'd0);

    step();
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that merges the Ibex instruction port, the Ibex data port and the Vicuna vector memory port into the single request/response stream consumed by `mmu`. It holds one transaction in flight at a time and keeps the request fields stable until `mmu` answers. It returns the response to the owning requester. A timeout closes transactions that `mmu` never answers, such as GPIO and timer writes.

## Interface
Parameters:
- `MEM_W`, 32, data bus width in bits; must equal `mmu` `MEM_W`.
- `N_PORTS`, 3, number of requesters; port 0 = instr, 1 = data, 2 = vector.
- `TIMEOUT_CYCLES`, 64, number of BUSY cycles with no response before forced completion; must be ≥ 2.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_i` in [N_PORTS]: per-port request.
- `addr_i` in [N_PORTS][32]: per-port address.
- `we_i` in [N_PORTS]: 1 = write.
- `be_i` in [N_PORTS][MEM_W/8]: byte enables.
- `wdata_i` in [N_PORTS][MEM_W]: write data.
- `gnt_o` out [N_PORTS]: one-cycle acceptance pulse, at most one bit high.
- `rvalid_o` out [N_PORTS]: one-cycle response pulse to the owner.
- `err_o` out [N_PORTS]: error qualifier, valid with `rvalid_o`.
- `rdata_o` out [MEM_W]: read data, shared, valid with `rvalid_o`.
- `mem_req_o` out 1: drives `mmu` `vproc_mem_req_o`.
- `mem_addr_o` out 32: drives `vproc_mem_addr_o`.
- `mem_we_o` out 1: drives `vproc_mem_we_o`.
- `mem_be_o` out [MEM_W/8]: drives `vproc_mem_be_o`.
- `mem_wdata_o` out [MEM_W]: drives `vproc_mem_wdata_o`.
- `mem_rvalid_i` in 1: from `vproc_mem_rvalid_i`.
- `mem_err_i` in 1: from `vproc_mem_err_i`.
- `mem_rdata_i` in [MEM_W]: from `vproc_mem_rdata_i`.

## Operation
- States: IDLE and BUSY. Reset state is IDLE.
- **IDLE:**
  - If any `req_i` is high, the round-robin winner receives `gnt_o` combinationally in that cycle.
  - The winner's addr/we/be/wdata and its index are captured into the owner register.
  - Next state is BUSY.
  - With no request, the block stays in IDLE.
- **Round robin:**
  - The search starts at `rr_ptr` and proceeds upward, wrapping modulo `N_PORTS`.
  - After a grant to port k, `rr_ptr` becomes (k+1) mod `N_PORTS`.
  - `rr_ptr` resets to 0.
- **BUSY:**
  - `mem_req_o`=1 and the `mem_*` fields are driven from the capture registers, held constant every BUSY cycle.
  - The timeout counter increments each cycle.
  - If `mem_rvalid_i` or `mem_err_i` is high: owner `rvalid_o`=1, `err_o`=`mem_err_i`, `rdata_o`=`mem_rdata_i` in the same cycle; next state is IDLE.
  - If `mem_err_i` is high without `mem_rvalid_i`, it still completes the transaction, with `rvalid_o`=1 and `err_o`=1.
  - **Timeout:** if the counter equals `TIMEOUT_CYCLES`-1 and no response arrives, the owner gets `rvalid_o`=1, `err_o`=~captured `we`, `rdata_o`=0. Writes are treated as posted; reads are errors. Next state is IDLE.
  - A response in the timeout cycle wins over the timeout.
- No `gnt_o` is issued in BUSY; requesters hold `req_i` until they are granted.
- Responses go only to the captured owner index; every other `rvalid_o` bit is 0.

## Timing
- Reset values: `gnt_o`, `rvalid_o`, `err_o` = 0; `rdata_o` = 0; `mem_req_o` = 0; `mem_addr_o`/`we`/`be`/`wdata` = 0; capture registers, counter and `rr_ptr` = 0.
- Grant in cycle t (IDLE). `mem_req_o` rises at t+1 and stays high through the response cycle. It is low in the cycle after the response.
- Minimum transaction time is 2 cycles: grant, then BUSY with an immediate response. Back-to-back transactions always include one IDLE cycle.
- Maximum BUSY duration is `TIMEOUT_CYCLES` cycles.
- Counter width is $clog2(TIMEOUT_CYCLES). It clears on IDLE→BUSY.
- Reset asserted mid-transaction drops the in-flight transaction with no response. All outputs go to their reset values asynchronously.
- `rdata_o` is 0 whenever `rvalid_o` is low.

## Structure
- Package `mem_arb_pkg`:
  - port index constants `PORT_INSTR`=0, `PORT_DATA`=1, `PORT_VEC`=2;
  - state enum {IDLE, BUSY};
  - `mem_req_t` struct {addr, we, be, wdata} for the capture register.
- Sub-module `rr_arbiter`: inputs are the request vector and `rr_ptr`; outputs are the one-hot grant and the winner index. It is combinational. The pointer register lives in `mem_arbiter`.

## Test plan
- **Single read:** port 1 reads 0x2000 and `mmu` model answers at BUSY cycle 3 with rdata 0xDEADBEEF → `gnt_o`[1] pulses once; `mem_req_o` is high 3 cycles with addr 0x2000 stable; `rvalid_o`[1]=1, `err_o`=0, `rdata_o`=0xDEADBEEF.
- **Round robin:** all three ports request continuously with immediate responses → grant order 0,1,2,0,1,2, one IDLE cycle between grants.
- **Posted write timeout:** port 2 writes 0x0000_010B and `mmu` never answers, with `TIMEOUT_CYCLES`=4 → `rvalid_o`[2]=1, `err_o`=0 at BUSY cycle 4; `mem_req_o` is low next cycle.
- **Read timeout:** port 0 reads 0x0000_0115 with no answer → `rvalid_o`[0]=1, `err_o`=1, `rdata_o`=0 at BUSY cycle `TIMEOUT_CYCLES`.
- **Error response:** `mem_err_i` pulses at BUSY cycle 2 for a port 1 write to 0x3000 → `rvalid_o`[1]=1, `err_o`[1]=1; state returns to IDLE.
- **Reset mid-BUSY:** assert `rst` during BUSY cycle 2 of a port 1 read → all outputs 0 immediately, no `rvalid_o`. After release, a pending port 2 request is granted before port 1 only if port 1 is idle, since `rr_ptr` is 0.
